// File: rtl/op2_shift_stage.sv
// ARM operand-2 decode stage in front of an external 32-bit barrel shifter.
// Optional output register enabled by defining OP2_OUTREG_EN (latency 2, else latency 1).
module op2_shift_stage #(
    parameter int          AMT_W     = 8,
    parameter logic [31:0] RESET_OP2 = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        i_bit,
    input  logic [11:0] op_field,
    input  logic [31:0] rm_val,
    input  logic [31:0] rs_val,
    input  logic        c_in,
    output logic [31:0] sh_a,
    output logic [4:0]  sh_shamt5,
    output logic [1:0]  sh_sel,
    input  logic [31:0] sh_y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op2,
    output logic        shift_carry
);

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Carry-out of an in-range (1..31) shift, taken straight from the operand bits.
    function automatic logic norm_carry(input logic [1:0] typ, input logic [31:0] rm,
                                        input logic [4:0] n);
        logic [4:0] idx;
        if (typ == SH_LSL)
            idx = 5'd0 - n;
        else
            idx = n - 5'd1;
        return rm[idx];
    endfunction

    logic             vld_p0;
    logic             ibit_p0;
    logic [11:0]      op_p0;
    logic [31:0]      rm_p0;
    logic [AMT_W-1:0] amt_p0;
    logic             cin_p0;

    logic [31:0]      n_ext;
    logic [1:0]       typ;
    logic [31:0]      fix_op2;
    logic             fix_c;

    logic             unused_bits;

    generate
        if (AMT_W < 32) begin : g_rs_unused
            assign unused_bits = ^{rs_val[31:AMT_W], op_p0[3:0]};
        end else begin : g_rs_full
            assign unused_bits = ^op_p0[3:0];
        end
    endgenerate

    // ---- Stage p0: capture operand fields ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0  <= 1'b0;
            ibit_p0 <= 1'b0;
            op_p0   <= '0;
            rm_p0   <= '0;
            amt_p0  <= '0;
            cin_p0  <= 1'b0;
        end else if (in_ready) begin
            vld_p0 <= in_valid;
            if (in_valid) begin
                ibit_p0 <= i_bit;
                op_p0   <= op_field;
                rm_p0   <= rm_val;
                amt_p0  <= rs_val[AMT_W-1:0];
                cin_p0  <= c_in;
            end
        end
    end

    // ---- Decode, shifter drive and fix-up (combinational from p0) ----
    always_comb begin
        typ       = op_p0[6:5];
        n_ext     = '0;
        sh_a      = rm_p0;
        sh_sel    = typ;
        sh_shamt5 = '0;
        fix_op2   = sh_y;
        fix_c     = 1'b0;

        if (ibit_p0) begin
            sh_a      = {24'b0, op_p0[7:0]};
            sh_shamt5 = {op_p0[11:8], 1'b0};
            sh_sel    = SH_ROR;
            fix_op2   = sh_y;
            fix_c     = (op_p0[11:8] == 4'd0) ? cin_p0 : sh_y[31];
        end else begin
            if (op_p0[4])
                n_ext = 32'(amt_p0);
            else
                n_ext = {27'b0, op_p0[11:7]};
            sh_shamt5 = n_ext[4:0];

            if (n_ext == 32'd0) begin
                // A zero immediate amount re-encodes LSR/ASR #32 and RRX.
                if (!op_p0[4]) begin
                    case (typ)
                        SH_LSL: begin fix_op2 = rm_p0;                  fix_c = cin_p0;    end
                        SH_LSR: begin fix_op2 = '0;                     fix_c = rm_p0[31]; end
                        SH_ASR: begin fix_op2 = {32{rm_p0[31]}};        fix_c = rm_p0[31]; end
                        default: begin fix_op2 = {cin_p0, rm_p0[31:1]}; fix_c = rm_p0[0];  end
                    endcase
                end else begin
                    fix_op2 = rm_p0;
                    fix_c   = cin_p0;
                end
            end else if (n_ext < 32'd32) begin
                fix_op2 = sh_y;
                fix_c   = norm_carry(typ, rm_p0, n_ext[4:0]);
            end else begin
                // Register amounts of 32 and above; only reachable from Rs.
                case (typ)
                    SH_LSL: begin
                        fix_op2 = '0;
                        fix_c   = (n_ext == 32'd32) ? rm_p0[0] : 1'b0;
                    end
                    SH_LSR: begin
                        fix_op2 = '0;
                        fix_c   = (n_ext == 32'd32) ? rm_p0[31] : 1'b0;
                    end
                    SH_ASR: begin
                        fix_op2 = {32{rm_p0[31]}};
                        fix_c   = rm_p0[31];
                    end
                    default: begin
                        if (n_ext[4:0] == 5'd0) begin
                            fix_op2 = rm_p0;
                            fix_c   = rm_p0[31];
                        end else begin
                            fix_op2 = sh_y;
                            fix_c   = norm_carry(SH_ROR, rm_p0, n_ext[4:0]);
                        end
                    end
                endcase
            end
        end
    end

`ifdef OP2_OUTREG_EN
    logic        vld_p1;
    logic [31:0] op2_p1;
    logic        c_p1;

    assign in_ready = !reset && (!vld_p0 || !vld_p1 || out_ready);

    // ---- Stage p1: registered operand 2, held while the consumer stalls ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            op2_p1 <= RESET_OP2;
            c_p1   <= 1'b0;
        end else if (!vld_p1 || out_ready) begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                op2_p1 <= fix_op2;
                c_p1   <= fix_c;
            end
        end
    end

    assign out_valid   = vld_p1;
    assign op2         = op2_p1;
    assign shift_carry = c_p1;
`else
    assign in_ready    = !reset && (!vld_p0 || out_ready);
    assign out_valid   = vld_p0;
    assign op2         = fix_op2;
    assign shift_carry = fix_c;
`endif

endmodule
